// File: rtl/bus_if_pkg.sv
// Shared bus types and constants for cross-bar endpoints.
// Provides address/data widths, payload typedefs and the slave FSM state encoding.
package bus_if_pkg;

  localparam int unsigned AW             = 16;
  localparam int unsigned DW             = 32;
  localparam int unsigned WAIT_W         = 4;
  localparam int unsigned MAX_RD_LATENCY = 8;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } slave_state_e;

endpackage

// File: rtl/bus_slave_rd_pipe.sv
// Read-response delay line: RD_LATENCY stages of valid/data/err.
// Ports: clk, reset (async, active-high, clears valid bits only),
//        in_valid/in_data/in_err (stage 0 input), out_valid/out_data/out_err (last stage).
// out_data and out_err are forced to 0 whenever out_valid is low.
module bus_slave_rd_pipe
  import bus_if_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_err,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  logic [RD_LATENCY-1:0] valid_q, valid_d;
  logic [RD_LATENCY-1:0] err_q, err_d;
  logic [DW-1:0]         data_q [RD_LATENCY];
  logic [DW-1:0]         data_d [RD_LATENCY];

  // Shift by one stage per clock; stage 0 takes the new entry.
  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    data_d[0]  = in_data;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    err_q  <= err_d;
    data_q <= data_d;
  end

  assign out_valid = valid_q[RD_LATENCY-1];
  assign out_data  = valid_q[RD_LATENCY-1] ? data_q[RD_LATENCY-1] : '0;
  assign out_err   = valid_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];

endmodule

// File: rtl/bus_slave_mem.sv
// Cross-bar slave endpoint serving requests from an internal word memory,
// with programmable wait states and read latency.
// Ports: clk, reset (async, active-high); req/we/addr/wdata from the master;
//        ack (one-cycle accept pulse), resp/rdata (read return, rdata 0 unless resp),
//        err (decode error, only when BUS_SLAVE_MEM_ERR_EN is defined).
// Optional feature macro: BUS_SLAVE_MEM_ERR_EN -- out-of-range addresses flag err,
// suppress writes and return zero read data; otherwise upper address bits alias.
module bus_slave_mem
  import bus_if_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          resp,
  output logic [DW-1:0] rdata
`ifdef BUS_SLAVE_MEM_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  slave_state_e      state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_ack_q, err_ack_d;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0]  idx_c;
  logic              oor_c;
  logic              acc_c;
  logic [DW-1:0]     rd_word_c;
  logic              pipe_err;

  assign idx_c = addr[IDX_W-1:0];

`ifdef BUS_SLAVE_MEM_ERR_EN
  assign oor_c = (addr >> IDX_W) != '0;
`else
  // Upper address bits are intentionally ignored (accesses alias onto the index).
  logic unused_addr_hi;
  assign unused_addr_hi = |(addr >> IDX_W);
  assign oor_c          = 1'b0;
`endif

  // Request FSM: IDLE -> [WAIT x WAIT_STATES] -> ACK -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        // A master dropping req mid-wait abandons the request without an access.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_W'(WAIT_STATES)) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ack_d     = (state_d == ST_ACK);
    err_ack_d = (state_d == ST_ACK) & oor_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_ack_q <= err_ack_d;
    end
  end

  // The ACK cycle is the single access cycle for both reads and writes.
  assign acc_c = (state_q == ST_ACK);

  always_ff @(posedge clk) begin
    if (acc_c && we && !oor_c) begin
      mem_q[idx_c] <= wdata;
    end
  end

  assign rd_word_c = oor_c ? '0 : mem_q[idx_c];

  bus_slave_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (acc_c & ~we),
    .in_data  (rd_word_c),
    .in_err   (oor_c),
    .out_valid(resp),
    .out_data (rdata),
    .out_err  (pipe_err)
  );

  assign ack = ack_q;

`ifdef BUS_SLAVE_MEM_ERR_EN
  // Ack-cycle and resp-cycle errors are independent and may coincide.
  assign err = err_ack_q | pipe_err;
`else
  logic unused_err;
  assign unused_err = pipe_err | err_ack_q;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
module tb_bus_slave_mem;
  import bus_if_pkg::*;

  localparam int NI    = 4;
  localparam int DEPTH = 256;
`ifdef BUS_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic int ws_of(input int k);
    case (k)
      0: return 0;
      1: return 3;
      2: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int rl_of(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 8;
      default: return 4;
    endcase
  endfunction

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  logic  req   [NI];
  logic  we    [NI];
  addr_t addr  [NI];
  data_t wdata [NI];
  logic  ack   [NI];
  logic  resp  [NI];
  data_t rdata [NI];
`ifdef BUS_SLAVE_MEM_ERR_EN
  logic  err   [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_slave_mem #(
      .DEPTH      (DEPTH),
      .WAIT_STATES(ws_of(g)),
      .RD_LATENCY (rl_of(g))
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .req  (req[g]),
      .we   (we[g]),
      .addr (addr[g]),
      .wdata(wdata[g]),
      .ack  (ack[g]),
      .resp (resp[g]),
      .rdata(rdata[g])
`ifdef BUS_SLAVE_MEM_ERR_EN
      ,
      .err  (err[g])
`endif
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image per instance, expected ack cycle, pending responses.
  typedef struct {
    int    k;
    int    due;
    data_t d;
    bit    e;
  } rsp_t;

  typedef struct {
    int    k;
    bit    w;
    int    a;
    data_t d;
    data_t exp_d;
  } vec_t;

  rsp_t  rq [$];
  vec_t  tbl [$];
  data_t mem_m [NI][DEPTH];
  int    exp_ack [NI];
  bit    exp_ack_err [NI];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, k, cyc, act, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      bit    ea  = (exp_ack[k] == cyc);
      int    hit = -1;
      data_t ed;
      bit    ee;
      for (int j = 0; j < rq.size(); j++) begin
        if (rq[j].k == k && rq[j].due == cyc) hit = j;
      end
      ed = (hit >= 0) ? rq[hit].d : '0;
      ee = (ea && exp_ack_err[k]) || (hit >= 0 && rq[hit].e);
      chk("ack", k, 64'(ack[k]), 64'(ea));
      chk("resp", k, 64'(resp[k]), 64'(hit >= 0));
      chk("rdata", k, 64'(rdata[k]), 64'(ed));
`ifdef BUS_SLAVE_MEM_ERR_EN
      chk("err", k, 64'(err[k]), 64'(ee));
`else
      if (ee) begin
        checks++;
        errors++;
        $display("FAIL err_model inst%0d cyc%0d: got 0 expected 1", k, cyc);
      end
`endif
      if (hit >= 0) rq.delete(hit);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  // Present one request right after a negedge; returns one cycle after its ack with req low.
  task automatic txn(input int k, input bit w, input int a, input data_t d,
                     input bit use_exp, input data_t exp_d);
    int    ea;
    int    idx;
    bit    oor;
    data_t rd;
    idx = a % DEPTH;
    oor = (a >= DEPTH);
    ea  = cyc + 1 + ws_of(k);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = addr_t'(a);
    wdata[k] = d;
    exp_ack[k]     = ea;
    exp_ack_err[k] = ERR_EN && oor;
    while (cyc < ea) step();
    if (w) begin
      if (!(ERR_EN && oor)) mem_m[k][idx] = d;
    end else begin
      rd = (ERR_EN && oor) ? '0 : mem_m[k][idx];
      if (use_exp) rd = exp_d;
      rq.push_back('{k, ea + rl_of(k), rd, ERR_EN && oor});
    end
    step();
    req[k]   = 1'b0;
    we[k]    = 1'b0;
    addr[k]  = '0;
    wdata[k] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc%0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      exp_ack[k] = -1; exp_ack_err[k] = 1'b0;
    end

    // Reset: all outputs low.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Directed table.
    tbl.push_back('{0, 1'b1, 'h005, 32'hDEADBEEF, 32'h0});
    tbl.push_back('{0, 1'b0, 'h005, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 'h000, 32'h11, 32'h0});
    tbl.push_back('{0, 1'b1, 'h100, 32'h55, 32'h0});
    tbl.push_back('{0, 1'b0, 'h000, 32'h0, ERR_EN ? 32'h11 : 32'h55});
    tbl.push_back('{0, 1'b0, 'h100, 32'h0, ERR_EN ? 32'h0 : 32'h55});
    tbl.push_back('{1, 1'b1, 'h010, 32'h12345678, 32'h0});
    tbl.push_back('{1, 1'b0, 'h010, 32'h0, 32'h12345678});
    tbl.push_back('{2, 1'b1, 'h001, 32'hA1, 32'h0});
    tbl.push_back('{2, 1'b1, 'h002, 32'hA2, 32'h0});
    tbl.push_back('{2, 1'b1, 'h003, 32'hA3, 32'h0});
    tbl.push_back('{3, 1'b1, 'h020, 32'hCAFE0001, 32'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      txn(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, !tbl[i].w, tbl[i].exp_d);
      step();
    end
    repeat (10) step();

    // Back-to-back reads, RD_LATENCY=8: later acks land on earlier resp cycles.
    txn(2, 1'b0, 'h001, '0, 1'b1, 32'hA1);
    txn(2, 1'b0, 'h002, '0, 1'b1, 32'hA2);
    txn(2, 1'b0, 'h003, '0, 1'b1, 32'hA3);
    txn(2, 1'b0, 'h001, '0, 1'b1, 32'hA1);
    txn(2, 1'b0, 'h002, '0, 1'b1, 32'hA2);
    repeat (12) step();

    // Abandoned write with 5 wait states: no ack, memory unchanged, FSM idle again.
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = addr_t'('h020); wdata[3] = 32'h0BAD0BAD;
    step();
    step();
    req[3] = 1'b0; we[3] = 1'b0; addr[3] = '0; wdata[3] = '0;
    repeat (10) step();
    txn(3, 1'b0, 'h020, '0, 1'b1, 32'hCAFE0001);
    repeat (8) step();

    // Reset one cycle after a read ack discards the pending response.
    txn(1, 1'b0, 'h010, '0, 1'b1, 32'h12345678);
    reset = 1'b1;
    rq.delete();
    for (int k = 0; k < NI; k++) exp_ack[k] = -1;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    txn(1, 1'b0, 'h010, '0, 1'b1, 32'h12345678);
    repeat (8) step();

    // Randomized traffic against the model, including aliased addresses.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) begin
        txn(k, 1'b1, 'h30 + i, data_t'($urandom), 1'b0, '0);
      end
      for (int i = 0; i < 40; i++) begin
        int a;
        a = 'h30 + int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a += DEPTH * int'($urandom_range(1, 3));
        txn(k, 1'($urandom_range(0, 1)), a, data_t'($urandom), 1'b0, '0);
        repeat ($urandom_range(0, 2)) step();
      end
      repeat (10) step();
    end

    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", rq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
